param_serializer: RTL and testbench

Parametrised parallel-to-serial converter for the serial link datapath. It accepts a DATA_W-bit word plus a programmable bit count and shifts the selected bits out one per clock, MSB-first or LSB-first. It supports gapless back-to-back words and flags rejected requests. It supersedes the fixed 16-bit serializer and adds bit order, a last-bit marker, error reporting and registered outputs.

---
 rtl/param_serializer.sv | 104 ++++++++++
 tb/tb_param_serializer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_serializer.sv
// Parallel-to-serial converter: sends L selected bits of a DATA_W word, MSB- or LSB-first,
// with gapless back-to-back words, a last-bit marker and a reject pulse.
module param_serializer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MOD_W   = $clog2(DATA_W) + 1,
  parameter int unsigned MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_val_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              lsb_first_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [MOD_W-1:0]  cnt_q, cnt_d;
  logic              lsb_q, lsb_d;
  logic              err_q, err_d;

  logic [MOD_W:0]    len;
  logic              len_ok;
  logic              busy;
  logic              last;
  logic              accept;

  // One extra bit so that the 0 -> DATA_W mapping and the range test never overflow.
  always_comb begin
    len    = (data_mod_i == '0) ? (MOD_W+1)'(DATA_W) : {1'b0, data_mod_i};
    len_ok = (len >= (MOD_W+1)'(MIN_LEN)) && (len <= (MOD_W+1)'(DATA_W));
  end

  assign last   = (state_q == SHIFT) && (cnt_q == '0);
  assign busy   = (state_q == SHIFT) && (cnt_q != '0);
  assign accept = data_val_i && len_ok && !busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    lsb_d   = lsb_q;
    err_d   = data_val_i && !accept;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = data_i;
          cnt_d   = MOD_W'(len - (MOD_W+1)'(1));
          lsb_d   = lsb_first_i;
        end
      end
      SHIFT: begin
        if (last) begin
          // Final bit on the wire: reload for a gapless next word, else drop to IDLE.
          if (accept) begin
            shreg_d = data_i;
            cnt_d   = MOD_W'(len - (MOD_W+1)'(1));
            lsb_d   = lsb_first_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shreg_d = lsb_q ? {1'b0, shreg_q[DATA_W-1:1]} : {shreg_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q - MOD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ser_data_val_o = (state_q == SHIFT);
  assign ser_data_o     = (state_q == SHIFT) ? (lsb_q ? shreg_q[0] : shreg_q[DATA_W-1]) : 1'b0;
  assign last_o         = last;
  assign busy_o         = busy;
  assign err_o          = err_q;

endmodule

// File: tb/tb_param_serializer.sv
// Self-checking bench for param_serializer (DATA_W=16, MIN_LEN=3) against a queue-based
// model of the expected serial stream.
module tb_param_serializer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        data_val_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [4:0]  data_mod_i = '0;
  logic        lsb_first_i = 1'b0;
  logic        ser_data_o, ser_data_val_o, last_o, busy_o, err_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  param_serializer #(
    .DATA_W (16),
    .MIN_LEN(3)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_val_i    (data_val_i),
    .data_i        (data_i),
    .data_mod_i    (data_mod_i),
    .lsb_first_i   (lsb_first_i),
    .ser_data_o    (ser_data_o),
    .ser_data_val_o(ser_data_val_o),
    .last_o        (last_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: queue of (bit, last) still to appear on the wire; head is the current cycle.
  typedef struct {
    logic b;
    logic l;
  } ev_t;
  ev_t  q[$];
  logic m_err = 1'b0;

  function automatic logic [4:0] exp_vec();
    if (q.size() > 0) return {q[0].b, 1'b1, q[0].l, q.size() > 1, m_err};
    return {4'b0000, m_err};
  endfunction

  // Drive one cycle of inputs (at a falling edge), advance the model, wait for the next falling edge.
  task automatic tick(input logic r, input logic v, input logic [15:0] d, input logic [4:0] m,
                      input logic lsbf);
    int  len;
    logic bsy, ok;
    ev_t e;
    rst_i = r; data_val_i = v; data_i = d; data_mod_i = m; lsb_first_i = lsbf;
    if (r) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      len = (m == 0) ? 16 : int'(m);
      ok  = (len >= 3) && (len <= 16);
      bsy = q.size() > 1;
      if (q.size() > 0) void'(q.pop_front());
      m_err = v && (!ok || bsy);
      if (v && ok && !bsy)
        for (int i = 0; i < len; i++) begin
          e.b = lsbf ? d[i] : d[15-i];
          e.l = (i == len - 1);
          q.push_back(e);
        end
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 16'h0000, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, k == 1, 16'hFFFF, 5'd4, 1'b0);
      obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset k=%0d got %b exp 00000", k, obs);
      end
    end
    idle();
  endtask

  task automatic test_full_word();
    logic [4:0]  obs;
    logic [15:0] col = '0;
    int          lastpos = 0, lastcnt = 0, busycnt = 0;
    tick(1'b0, 1'b1, 16'hA5A5, 5'd0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL full_word k=%0d got %b exp %b", k, obs, exp_vec());
      end
      if (k <= 16) col = {col[14:0], ser_data_o};
      if (last_o) begin lastcnt++; lastpos = k; end
      if (busy_o) busycnt++;
      idle();
    end
    checks++;
    if (col !== 16'hA5A5 || lastcnt != 1 || lastpos != 16 || busycnt != 15) begin
      errors++;
      $display("FAIL full_word_seq got %h last %0d@%0d busy %0d exp a5a5 1@16 15",
               col, lastcnt, lastpos, busycnt);
    end
  endtask

  task automatic test_short_word();
    logic [4:0] obs;
    logic [5:0] col;
    int         lastpos;
    for (int o = 0; o < 2; o++) begin
      col = '0;
      lastpos = 0;
      tick(1'b0, 1'b1, 16'hAAAA, 5'd6, o == 1);
      for (int k = 1; k <= 7; k++) begin
        obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL short_word o=%0d k=%0d got %b exp %b", o, k, obs, exp_vec());
        end
        if (k <= 6) col = {col[4:0], ser_data_o};
        if (last_o) lastpos = k;
        idle();
      end
      checks++;
      if (col !== ((o == 1) ? 6'b010101 : 6'b101010) || lastpos != 6) begin
        errors++;
        $display("FAIL short_word_seq o=%0d got %b last@%0d", o, col, lastpos);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs;
    logic [9:0] col = '0;
    logic [9:0] lasts = '0;
    int         valcnt = 0;
    logic       val11 = 1'b1;
    tick(1'b0, 1'b1, 16'hAAAA, 5'd6, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back k=%0d got %b exp %b", k, obs, exp_vec());
      end
      if (k <= 10) begin
        col   = {col[8:0], ser_data_o};
        lasts = {lasts[8:0], last_o};
        if (ser_data_val_o) valcnt++;
      end
      if (k == 11) val11 = ser_data_val_o;
      if (k == 6) tick(1'b0, 1'b1, 16'hFFFF, 5'd4, 1'b0);
      else idle();
    end
    checks++;
    if (valcnt != 10 || val11 !== 1'b0 || col !== 10'b1010101111 || lasts !== 10'b0000010001) begin
      errors++;
      $display("FAIL back_to_back_seq val %0d/%b bits %b lasts %b exp 10/0 1010101111 0000010001",
               valcnt, val11, col, lasts);
    end
  endtask

  task automatic test_len_bounds();
    logic [4:0] obs;
    logic [2:0] col = '0;
    logic [4:0] bad [2] = '{5'd2, 5'd17};
    for (int b = 0; b < 2; b++) begin
      tick(1'b0, 1'b1, 16'hFFFF, bad[b], 1'b0);
      for (int k = 1; k <= 2; k++) begin
        obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
        checks++;
        if (obs !== ((k == 1) ? 5'b00001 : 5'b00000)) begin
          errors++;
          $display("FAIL len_bounds mod=%0d k=%0d got %b", bad[b], k, obs);
        end
        idle();
      end
    end
    tick(1'b0, 1'b1, 16'hC000, 5'd3, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL len3 k=%0d got %b exp %b", k, obs, exp_vec());
      end
      if (k <= 3) col = {col[1:0], ser_data_o};
      idle();
    end
    checks++;
    if (col !== 3'b110) begin
      errors++;
      $display("FAIL len3_seq got %b exp 110", col);
    end
  endtask

  task automatic test_busy_reject();
    logic [4:0]  obs;
    logic [15:0] col = '0;
    int          errpos = 0, errcnt = 0;
    tick(1'b0, 1'b1, 16'h1234, 5'd0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL busy_reject k=%0d got %b exp %b", k, obs, exp_vec());
      end
      if (k <= 16) col = {col[14:0], ser_data_o};
      if (err_o) begin errcnt++; errpos = k; end
      if (k == 3) tick(1'b0, 1'b1, 16'hFFFF, 5'd8, 1'b1);
      else idle();
    end
    checks++;
    if (col !== 16'h1234 || errcnt != 1 || errpos != 4) begin
      errors++;
      $display("FAIL busy_reject_seq got %h err %0d@%0d exp 1234 1@4", col, errcnt, errpos);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    tick(1'b0, 1'b1, 16'hBEEF, 5'd0, 1'b0);
    for (int k = 1; k <= 4; k++) idle();
    tick(1'b1, 1'b1, 16'h0F0F, 5'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_mid k=%0d got %b exp 00000", k, obs);
      end
      idle();
    end
    tick(1'b0, 1'b1, 16'h0005, 5'd3, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_after k=%0d got %b exp %b", k, obs, exp_vec());
      end
      idle();
    end
  endtask

  task automatic test_random();
    logic [4:0] obs;
    for (int k = 0; k < 600; k++) begin
      tick($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, 16'($urandom),
           ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 16)),
           1'($urandom));
      obs = {ser_data_o, ser_data_val_o, last_o, busy_o, err_o};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random k=%0d got %b exp %b", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short_word();
    test_back_to_back();
    test_len_bounds();
    test_busy_reject();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
